rv_imm_materializer: RTL and testbench
======================================

RV_IMM_MATERIALIZER -- requirements
Module: rv_imm_materializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, constant width in bits; only 64 is supported.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit, reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid_i, input, 1 bit, constant request valid.
REQ-005 SHALL have port req_ready_o, output, 1 bit, request accepted when high with req_valid_i.
REQ-006 SHALL have port req_imm_i, input, DATA_WIDTH bits, signed constant to load.
REQ-007 SHALL have port req_rd_i, input, 5 bits, destination register.
REQ-008 SHALL have port instr_valid_o, output, 1 bit, instruction word valid.
REQ-009 SHALL have port instr_ready_i, input, 1 bit, downstream accepts the word.
REQ-010 SHALL have port instr_o, output, 32 bits, RV64I instruction word.
REQ-011 SHALL have port instr_last_o, output, 1 bit, marks the final word of a sequence.
REQ-012 SHALL have port busy_o, output, 1 bit, high whenever state is not IDLE.

Function
REQ-013 SHALL be the inverse of the immediate generator: it emits the shortest fixed sequence whose execution leaves rd equal to req_imm_i.
REQ-014 SHALL drive req_ready_o high only in IDLE; a request is accepted on any cycle where req_valid_i and req_ready_o are both high, and imm and rd are registered on that cycle.
REQ-015 SHALL present the first word with instr_valid_o high in the cycle after acceptance.
REQ-016 SHALL advance one word per cycle in which instr_valid_o and instr_ready_i are both high.
REQ-017 SHALL hold instr_o and instr_last_o stable while instr_valid_o is high and instr_ready_i is low.
REQ-018 SHALL emit a single word, ADDI rd,x0,imm[11:0], for class S12 (imm in [-2048, 2047]).
REQ-019 SHALL, for class S32 (sign-extension of imm[31:0] equals imm, and not S12), emit LUI rd,U then ADDIW rd,rd,L.
REQ-020 SHALL compute U = bits[31:12] of (imm[31:0] + 0x800) modulo 2^32, and L = imm[11:0].
REQ-021 SHALL, for class S64 (all other values), with H = imm[63:32] and U/L computed from H as in REQ-020, emit in order: LUI, ADDIW, SLLI 11, ADDI imm[31:21], SLLI 11, ADDI imm[20:10], SLLI 10, ADDI imm[9:0].
REQ-022 SHALL zero-extend every ADDI chunk in the S64 sequence, so the chunk is always non-negative.
REQ-023 SHALL use the encodings LUI 0110111, ADDI 0010011/f3=000, ADDIW 0011011/f3=000, and SLLI 0010011/f3=001 with imm[11:6]=0.
REQ-024 SHALL use FSM states IDLE, ADDI0, LUI, ADDIW, SH1, AD1, SH2, AD2, SH3, AD3; IDLE moves to ADDI0 (S12) or LUI (S32/S64), and each later state advances on handshake.
REQ-025 SHALL return to IDLE on the handshake of the word carrying instr_last_o, with req_ready_o high on the next cycle.
REQ-026 SHALL assert instr_last_o only on the final word of the sequence.

Reset
REQ-027 SHALL, while rst_ni is low, immediately force state IDLE, instr_valid_o=0, instr_last_o=0, instr_o=0, busy_o=0 and req_ready_o=1.
REQ-028 SHALL discard any partially emitted sequence when reset asserts mid-sequence.

Configuration
REQ-029 SHALL, when RV_IMM_MAT_SKIP_ZERO_EN is defined, omit every ADDIW/ADDI in an S32 or S64 sequence whose immediate is zero; instr_last_o then moves to the last emitted word.
REQ-030 SHALL, when RV_IMM_MAT_SKIP_ZERO_EN is undefined, emit the fixed sequences exactly as in REQ-018 to REQ-021.

Structure
REQ-031 SHALL place the opcode/funct3 constants, the state enum and the class enum (S12/S32/S64) in shared package rv_pkg.
REQ-032 SHALL implement word assembly as sub-module rv_instr_enc, combinational, with inputs op, rd, rs1 and imm12/imm20/shamt, and output 32-bit word.

Verification
REQ-033 SHALL cover: imm=5, rd=1 -> one word 0x00500093 with last=1.
REQ-034 SHALL cover: imm=-1, rd=1 -> one word 0xFFF00093.
REQ-035 SHALL cover: imm=0x12345678, rd=10 -> 0x12345537, then 0x6785051B with last=1.
REQ-036 SHALL cover: imm=0x0000000100000000, rd=5 -> 0x000002B7, 0x0012829B, then six words ending in ADDI 0; with macro defined, five words ending in SLLI 10 with last=1.
REQ-037 SHALL cover: instr_ready_i held low for 3 cycles mid-sequence -> instr_o is stable and no word is lost or duplicated.
REQ-038 SHALL cover: rst_ni pulsed low after the 3rd word of an S64 sequence -> outputs match REQ-027 at once, and the next request starts cleanly.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and encoding constants for the RV64I constant materializer.
package rv_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [2:0] F3_ADD      = 3'b000;
  localparam logic [2:0] F3_SLL      = 3'b001;

  typedef enum logic [3:0] {
    StIdle, StAddi0, StLui, StAddiw, StSh1, StAd1, StSh2, StAd2, StSh3, StAd3
  } mat_state_e;

  typedef enum logic [1:0] {ClsS12, ClsS32, ClsS64} imm_cls_e;

  typedef enum logic [1:0] {OpLui, OpAddi, OpAddiw, OpSlli} instr_op_e;

  function automatic imm_cls_e classify(input logic [63:0] imm);
    if (imm[63:11] == {53{imm[11]}}) begin
      return ClsS12;
    end else if (imm[63:31] == {33{imm[31]}}) begin
      return ClsS32;
    end
    return ClsS64;
  endfunction

endpackage

// File: rtl/rv_instr_enc.sv
// Combinational assembler for the four instruction forms used by the materializer.
module rv_instr_enc
  import rv_pkg::*;
(
  input  instr_op_e   op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [11:0] imm12_i,
  input  logic [19:0] imm20_i,
  input  logic [5:0]  shamt_i,
  output logic [31:0] instr_o
);

  always_comb begin
    instr_o = '0;
    unique case (op_i)
      OpLui:   instr_o = {imm20_i, rd_i, OPC_LUI};
      OpAddi:  instr_o = {imm12_i, rs1_i, F3_ADD, rd_i, OPC_OP_IMM};
      OpAddiw: instr_o = {imm12_i, rs1_i, F3_ADD, rd_i, OPC_OP_IMM32};
      OpSlli:  instr_o = {6'b000000, shamt_i, rs1_i, F3_SLL, rd_i, OPC_OP_IMM};
      default: instr_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_imm_materializer.sv
// Turns a 64-bit constant into the shortest fixed RV64I sequence loading it into rd.
// Define RV_IMM_MAT_SKIP_ZERO_EN to drop ADDIW/ADDI words whose immediate is zero.
module rv_imm_materializer
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_imm_i,
  input  logic [4:0]            req_rd_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic                  instr_last_o,
  output logic                  busy_o
);

  mat_state_e      state_q, state_d, seq_next;
  logic [63:0]     imm_q;
  logic [4:0]      rd_q;
  imm_cls_e        cls_q;
  logic            req_hs, out_hs;
  logic [31:0]     src32;
  logic [19:0]     u_hi;
  logic [11:0]     lo12;
  logic            addiw_en, ad1_en, ad2_en, ad3_en;
  instr_op_e       enc_op;
  logic [4:0]      enc_rs1;
  logic [11:0]     enc_imm12;
  logic [5:0]      enc_shamt;
  logic [31:0]     enc_word;

  assign req_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign instr_valid_o = (state_q != StIdle);
  assign req_hs        = req_valid_i && req_ready_o;
  assign out_hs        = instr_valid_o && instr_ready_i;

  // S64 builds the upper half first; S32 builds the whole value from the low half.
  assign src32 = (cls_q == ClsS64) ? imm_q[63:32] : imm_q[31:0];
  assign lo12  = src32[11:0];
  // Rounds up when the ADDIW immediate will sign-extend negative.
  assign u_hi  = src32[31:12] + {19'b0, src32[11]};

`ifdef RV_IMM_MAT_SKIP_ZERO_EN
  assign addiw_en = |lo12;
  assign ad1_en   = |imm_q[31:21];
  assign ad2_en   = |imm_q[20:10];
  assign ad3_en   = |imm_q[9:0];
`else
  assign addiw_en = 1'b1;
  assign ad1_en   = 1'b1;
  assign ad2_en   = 1'b1;
  assign ad3_en   = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      imm_q   <= '0;
      rd_q    <= '0;
      cls_q   <= ClsS12;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        imm_q <= req_imm_i;
        rd_q  <= req_rd_i;
        cls_q <= classify(req_imm_i);
      end
    end
  end

  always_comb begin
    seq_next = StIdle;
    unique case (state_q)
      StLui:   seq_next = addiw_en ? StAddiw : ((cls_q == ClsS64) ? StSh1 : StIdle);
      StAddiw: seq_next = (cls_q == ClsS64) ? StSh1 : StIdle;
      StSh1:   seq_next = ad1_en ? StAd1 : StSh2;
      StAd1:   seq_next = StSh2;
      StSh2:   seq_next = ad2_en ? StAd2 : StSh3;
      StAd2:   seq_next = StSh3;
      StSh3:   seq_next = ad3_en ? StAd3 : StIdle;
      default: seq_next = StIdle;
    endcase

    state_d = state_q;
    if (state_q == StIdle) begin
      if (req_hs) begin
        state_d = (classify(req_imm_i) == ClsS12) ? StAddi0 : StLui;
      end
    end else if (out_hs) begin
      state_d = seq_next;
    end
  end

  always_comb begin
    enc_op    = OpAddi;
    enc_rs1   = rd_q;
    enc_imm12 = '0;
    enc_shamt = '0;
    unique case (state_q)
      StAddi0: begin
        enc_rs1   = 5'd0;
        enc_imm12 = imm_q[11:0];
      end
      StLui:   enc_op = OpLui;
      StAddiw: begin
        enc_op    = OpAddiw;
        enc_imm12 = lo12;
      end
      StSh1, StSh2: begin
        enc_op    = OpSlli;
        enc_shamt = 6'd11;
      end
      StSh3: begin
        enc_op    = OpSlli;
        enc_shamt = 6'd10;
      end
      StAd1:   enc_imm12 = {1'b0, imm_q[31:21]};
      StAd2:   enc_imm12 = {1'b0, imm_q[20:10]};
      StAd3:   enc_imm12 = {2'b00, imm_q[9:0]};
      default: enc_op    = OpAddi;
    endcase
    instr_o      = instr_valid_o ? enc_word : 32'h0;
    instr_last_o = instr_valid_o && (seq_next == StIdle);
  end

  rv_instr_enc u_enc (
    .op_i    (enc_op),
    .rd_i    (rd_q),
    .rs1_i   (enc_rs1),
    .imm12_i (enc_imm12),
    .imm20_i (u_hi),
    .shamt_i (enc_shamt),
    .instr_o (enc_word)
  );

endmodule

// File: tb/tb_rv_imm_materializer.sv
// Self-checking bench: directed table, random constants vs. an ISA-level model, stall and reset.
module tb_rv_imm_materializer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_imm_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic        instr_last_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_w[$];
  logic        got_l[$];
  logic [31:0] exp_w[$];

  always #5 clk_i = ~clk_i;

  rv_imm_materializer #(.DATA_WIDTH(64)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_imm_i     (req_imm_i),
    .req_rd_i      (req_rd_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_last_o  (instr_last_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Expected words from the loading rules, using plain integer arithmetic.
  task automatic build_expected(input logic [63:0] imm, input logic [4:0] rd);
    longint v;
    logic [31:0] h, hr;
    logic [11:0] c1, c2, c3;
    bit skip;
    v = longint'(imm);
    skip = 1'b0;
`ifdef RV_IMM_MAT_SKIP_ZERO_EN
    skip = 1'b1;
`endif
    exp_w.delete();
    if (v >= -2048 && v <= 2047) begin
      exp_w.push_back(enc_i(imm[11:0], 5'd0, 3'd0, rd, 7'h13));
    end else begin
      bit s32;
      s32 = (v == longint'(int'(v)));
      h   = s32 ? imm[31:0] : imm[63:32];
      hr  = h + 32'h800;
      exp_w.push_back({hr[31:12], rd, 7'h37});
      if (!(skip && h[11:0] == 12'd0)) exp_w.push_back(enc_i(h[11:0], rd, 3'd0, rd, 7'h1b));
      if (!s32) begin
        c1 = 12'((imm >> 21) & 64'h7ff);
        c2 = 12'((imm >> 10) & 64'h7ff);
        c3 = 12'(imm & 64'h3ff);
        exp_w.push_back(enc_i(12'd11, rd, 3'd1, rd, 7'h13));
        if (!(skip && c1 == 0)) exp_w.push_back(enc_i(c1, rd, 3'd0, rd, 7'h13));
        exp_w.push_back(enc_i(12'd11, rd, 3'd1, rd, 7'h13));
        if (!(skip && c2 == 0)) exp_w.push_back(enc_i(c2, rd, 3'd0, rd, 7'h13));
        exp_w.push_back(enc_i(12'd10, rd, 3'd1, rd, 7'h13));
        if (!(skip && c3 == 0)) exp_w.push_back(enc_i(c3, rd, 3'd0, rd, 7'h13));
      end
    end
  endtask

  // Executes the emitted words on a tiny RV64I register model and returns rd.
  function automatic logic [63:0] execute(input logic [4:0] rd);
    logic [63:0] x[32];
    logic [31:0] w, t32;
    logic [11:0] i12;
    logic [63:0] val;
    for (int i = 0; i < 32; i++) x[i] = '0;
    for (int k = 0; k < got_w.size(); k++) begin
      w   = got_w[k];
      i12 = w[31:20];
      val = '0;
      case (w[6:0])
        7'h37: val = {{32{w[31]}}, w[31:12], 12'h000};
        7'h13: val = (w[14:12] == 3'd0) ? x[w[19:15]] + {{52{i12[11]}}, i12}
                                         : x[w[19:15]] << w[25:20];
        7'h1b: begin
          t32 = x[w[19:15]][31:0] + {{20{i12[11]}}, i12};
          val = {{32{t32[31]}}, t32};
        end
        default: val = 64'hdead_beef_dead_beef;
      endcase
      if (w[11:7] != 5'd0) x[w[11:7]] = val;
    end
    return x[rd];
  endfunction

  task automatic send(input logic [63:0] imm, input logic [4:0] rd);
    int t;
    t = 0;
    while (!req_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("req_ready_wait", {63'd0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1;
    req_imm_i   = imm;
    req_rd_i    = rd;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("first_word_valid", {63'd0, instr_valid_o}, 64'd1);
  endtask

  // Collects words; holds ready low 3 cycles when stall_idx words have been taken.
  task automatic collect(input int stall_pct, input int stall_idx, input int stop_after);
    int t, hold;
    bit pstall, rdy, forced;
    logic [31:0] pw;
    logic pl;
    got_w.delete();
    got_l.delete();
    hold = 3; pstall = 0; t = 0; pw = '0; pl = 0;
    forever begin
      if (t >= 400) begin
        chk("collect_timeout", 64'(t), 64'd0);
        break;
      end
      if (instr_valid_o) begin
        if (pstall) begin
          chk("stall_word_stable", {32'd0, instr_o}, {32'd0, pw});
          chk("stall_last_stable", {63'd0, instr_last_o}, {63'd0, pl});
        end
        forced = (got_w.size() == stall_idx) && (hold > 0);
        if (forced) hold--;
        rdy = !forced && ($urandom_range(0, 99) >= stall_pct);
        instr_ready_i = rdy;
        pstall = !rdy;
        pw = instr_o;
        pl = instr_last_o;
        if (rdy) begin
          got_w.push_back(instr_o);
          got_l.push_back(instr_last_o);
        end
      end else begin
        instr_ready_i = 1'b0;
        pstall = 0;
      end
      @(negedge clk_i);
      t++;
      if (got_l.size() > 0 && got_l[got_l.size()-1]) break;
      if (stop_after > 0 && got_w.size() >= stop_after) break;
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic verify(input string name, input logic [63:0] imm, input logic [4:0] rd);
    build_expected(imm, rd);
    chk({name, "_len"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int k = 0; k < got_w.size() && k < exp_w.size(); k++) begin
      chk({name, "_word"}, {32'd0, got_w[k]}, {32'd0, exp_w[k]});
      chk({name, "_last"}, {63'd0, got_l[k]}, {63'd0, (k == exp_w.size() - 1)});
    end
    chk({name, "_exec"}, execute(rd), imm);
    chk({name, "_ready_after"}, {63'd0, req_ready_o}, 64'd1);
  endtask

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  rd;
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] wlast;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [63:0] v;
    int mode;
    logic [4:0] rd;

    vecs[0] = '{64'd5, 5'd1, 1, 32'h00500093, 32'h0, 32'h00500093};
    vecs[1] = '{64'hffff_ffff_ffff_ffff, 5'd1, 1, 32'hfff00093, 32'h0, 32'hfff00093};
    vecs[2] = '{64'h12345678, 5'd10, 2, 32'h12345537, 32'h6785051b, 32'h6785051b};
`ifdef RV_IMM_MAT_SKIP_ZERO_EN
    vecs[3] = '{64'h1_0000_0000, 5'd5, 5, 32'h000002b7, 32'h0012829b, 32'h00a29293};
`else
    vecs[3] = '{64'h1_0000_0000, 5'd5, 8, 32'h000002b7, 32'h0012829b, 32'h00028293};
`endif

    #1;
    chk("reset_ready", {63'd0, req_ready_o}, 64'd1);
    chk("reset_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_instr", {32'd0, instr_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) begin
      send(vecs[i].imm, vecs[i].rd);
      collect(0, -1, 0);
      chk("vec_len", 64'(got_w.size()), 64'(vecs[i].len));
      if (got_w.size() > 0) begin
        chk("vec_w0", {32'd0, got_w[0]}, {32'd0, vecs[i].w0});
        chk("vec_wlast", {32'd0, got_w[got_w.size()-1]}, {32'd0, vecs[i].wlast});
      end
      if (got_w.size() > 1) chk("vec_w1", {32'd0, got_w[1]}, {32'd0, vecs[i].w1});
      verify("vec", vecs[i].imm, vecs[i].rd);
    end

    // Ready held low for three cycles in the middle of an S64 sequence.
    send(64'h8765_4321_0fed_cba9, 5'd7);
    collect(0, 2, 0);
    verify("stall", 64'h8765_4321_0fed_cba9, 5'd7);

    // Reset after the third word of an S64 sequence.
    send(64'h1234_5678_9abc_def0, 5'd3);
    collect(0, -1, 3);
    chk("mid_words_taken", 64'(got_w.size()), 64'd3);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("midrst_last", {63'd0, instr_last_o}, 64'd0);
    chk("midrst_instr", {32'd0, instr_o}, 64'd0);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready_o}, 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send(64'd5, 5'd1);
    collect(0, -1, 0);
    verify("post_rst", 64'd5, 5'd1);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 4);
      v = {$urandom(), $urandom()};
      case (mode)
        0: v = {{52{v[11]}}, v[11:0]};
        1: v = {{32{v[31]}}, v[31:0]};
        2: v = {{32{v[31]}}, v[31:12], 12'h000};
        3: begin
          if (v[0]) v[31:21] = '0;
          if (v[1]) v[20:10] = '0;
          if (v[2]) v[9:0] = '0;
          if (v[3]) v[43:32] = '0;
        end
        default: ;
      endcase
      rd = 5'($urandom_range(1, 31));
      send(v, rd);
      collect(30, -1, 0);
      verify("rand", v, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
